// File: rtl/wresp_chan_slave.sv
// Write response queue: one {id, ok} entry per finished burst, returned in completion order on bvalid/bready.
// One cycle wr_done -> bvalid; push while full is dropped (sticky wresp_ovf) unless a pop frees the slot that cycle.
module wresp_chan_slave #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_done,
  input  logic [3:0] wr_done_id,
  input  logic       wr_done_ok,
  output logic       bvalid,
  input  logic       bready,
  output logic [3:0] bid,
  output logic       bcomp,
  output logic       wresp_full,
  output logic       wresp_empty,
  output logic       wresp_ovf
);

  typedef struct packed {
    logic [3:0] id;
    logic       ok;
  } resp_t;

  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  resp_t            mem_q [DEPTH];
  resp_t            mem_d [DEPTH];
  logic [PTR_W-1:0] wp_q, wp_d;
  logic [PTR_W-1:0] rp_q, rp_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic pop;
  logic push;
  logic ovf_set;

  assign bvalid      = (cnt_q != '0);
  assign bid         = bvalid ? mem_q[rp_q].id : 4'd0;
  assign bcomp       = bvalid ? mem_q[rp_q].ok : 1'b0;
  assign wresp_full  = (cnt_q == CNT_FULL);
  assign wresp_empty = (cnt_q == '0);
  assign wresp_ovf   = ovf_q;

  // A pop in the same cycle frees the head slot, so a push into a full queue is still accepted.
  assign pop     = bvalid & bready;
  assign push    = wr_done & (~wresp_full | pop);
  assign ovf_set = wr_done & wresp_full & ~pop;

  always_comb begin
    mem_d = mem_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (push) begin
      mem_d[wp_q] = '{id: wr_done_id, ok: wr_done_ok};
      wp_d        = wp_q + PTR_W'(1);
    end
    if (pop) begin
      rp_d = rp_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
      2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
      default: cnt_d = cnt_q;
    endcase
    if (ovf_set) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: tb/tb_wresp_chan_slave.sv
// Directed bench for wresp_chan_slave: expected responses queued at stimulus, checked by a negedge monitor.
module tb_wresp_chan_slave;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_done = 1'b0;
  logic [3:0] wr_done_id = 4'd0;
  logic       wr_done_ok = 1'b0;
  logic       bvalid;
  logic       bready = 1'b0;
  logic [3:0] bid;
  logic       bcomp;
  logic       wresp_full;
  logic       wresp_empty;
  logic       wresp_ovf;

  int n_total = 0;
  int n_pass  = 0;

  logic [4:0] exp_q [$];

  wresp_chan_slave #(.DEPTH(4), .PTR_W(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_done    (wr_done),
    .wr_done_id (wr_done_id),
    .wr_done_ok (wr_done_ok),
    .bvalid     (bvalid),
    .bready     (bready),
    .bid        (bid),
    .bcomp      (bcomp),
    .wresp_full (wresp_full),
    .wresp_empty(wresp_empty),
    .wresp_ovf  (wresp_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one wr_done pulse; queue the expected response when it should be accepted.
  task automatic push(input logic [3:0] id, input logic ok, input bit accepted);
    wr_done    = 1'b1;
    wr_done_id = id;
    wr_done_ok = ok;
    if (accepted) exp_q.push_back({id, ok});
    tick();
    wr_done = 1'b0;
  endtask

  task automatic drain(input int n);
    bready = 1'b1;
    repeat (n) tick();
    bready = 1'b0;
  endtask

  // Monitor: compares each handshaken response and checks hold-while-stalled.
  logic       prev_vld = 1'b0;
  logic       prev_hs  = 1'b0;
  logic [3:0] prev_id  = 4'd0;
  logic       prev_ok  = 1'b0;
  logic [4:0] front;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_vld = 1'b0;
      prev_hs  = 1'b0;
    end else begin
      if (prev_vld && !prev_hs) begin
        check("hold_bvalid", int'(bvalid), 1);
        check("hold_bid", int'(bid), int'(prev_id));
        check("hold_bcomp", int'(bcomp), int'(prev_ok));
      end
      if (bvalid && bready) begin
        if (exp_q.size() == 0) begin
          check("spurious_response", 1, 0);
        end else begin
          front = exp_q.pop_front();
          check("resp_bid", int'(bid), int'(front[4:1]));
          check("resp_bcomp", int'(bcomp), int'(front[0]));
        end
      end
      prev_vld = bvalid;
      prev_hs  = bvalid & bready;
      prev_id  = bid;
      prev_ok  = bcomp;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and idle.
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("rst_bvalid", int'(bvalid), 0);
    check("rst_bid", int'(bid), 0);
    check("rst_bcomp", int'(bcomp), 0);
    check("rst_full", int'(wresp_full), 0);
    check("rst_empty", int'(wresp_empty), 1);
    check("rst_ovf", int'(wresp_ovf), 0);
    for (int i = 0; i < 10; i++) begin
      bready = i[0];
      tick();
      check("idle_bvalid", int'(bvalid), 0);
      check("idle_bid", int'(bid), 0);
      check("idle_empty", int'(wresp_empty), 1);
    end
    bready = 1'b0;

    // Single response, stalled 3 cycles.
    push(4'h5, 1'b1, 1'b1);
    check("single_bvalid", int'(bvalid), 1);
    check("single_bid", int'(bid), 5);
    check("single_bcomp", int'(bcomp), 1);
    repeat (3) tick();
    drain(1);
    check("single_drop_bvalid", int'(bvalid), 0);
    check("single_drop_bid", int'(bid), 0);
    check("single_empty", int'(wresp_empty), 1);

    // Fill then ordered drain.
    push(4'h1, 1'b1, 1'b1);
    push(4'h2, 1'b0, 1'b1);
    push(4'h3, 1'b1, 1'b1);
    push(4'h4, 1'b1, 1'b1);
    check("fill_full", int'(wresp_full), 1);
    check("fill_empty", int'(wresp_empty), 0);
    drain(4);
    check("fill_drain_empty", int'(wresp_empty), 1);
    check("fill_drain_bvalid", int'(bvalid), 0);

    // Full with simultaneous push and pop.
    for (int i = 1; i <= 4; i++) push(4'(i), 1'b1, 1'b1);
    bready = 1'b1;
    push(4'h9, 1'b0, 1'b1);
    bready = 1'b0;
    check("pushpop_full", int'(wresp_full), 1);
    check("pushpop_ovf", int'(wresp_ovf), 0);
    check("pushpop_head", int'(bid), 2);
    drain(4);
    check("pushpop_empty", int'(wresp_empty), 1);

    // Overflow: dropped entry, sticky flag.
    for (int i = 1; i <= 4; i++) push(4'(i), i[0], 1'b1);
    push(4'hA, 1'b1, 1'b0);
    check("ovf_set", int'(wresp_ovf), 1);
    check("ovf_full", int'(wresp_full), 1);
    check("ovf_head", int'(bid), 1);
    drain(4);
    check("ovf_drain_empty", int'(wresp_empty), 1);
    check("ovf_sticky", int'(wresp_ovf), 1);
    tick();
    check("ovf_no_extra", int'(bvalid), 0);

    // Reset mid-operation.
    push(4'h1, 1'b1, 1'b1);
    push(4'h2, 1'b1, 1'b1);
    push(4'h3, 1'b1, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_bvalid", int'(bvalid), 0);
    check("midrst_bid", int'(bid), 0);
    check("midrst_empty", int'(wresp_empty), 1);
    check("midrst_ovf", int'(wresp_ovf), 0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    push(4'h7, 1'b0, 1'b1);
    check("postrst_bvalid", int'(bvalid), 1);
    check("postrst_bid", int'(bid), 7);
    check("postrst_full", int'(wresp_full), 0);
    drain(1);
    check("postrst_empty", int'(wresp_empty), 1);

    tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
